// File: rtl/mouse_bus_interface.sv
// Mouse packet to bus-register bridge: accumulates a clamped cursor position and raises a level interrupt per packet.
// Optional bus write of X/Y position is enabled by defining MOUSE_BUS_WRITE_POS_EN.
module mouse_bus_interface #(
  parameter logic [7:0] BASE_ADDR = 8'hA0,
  parameter int         LIMIT_X   = 160,
  parameter int         LIMIT_Y   = 120
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_DX,
  input  logic [7:0] MOUSE_DY,
  input  logic       SEND_INTERRUPT,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [7:0] BUS_DATA_IN,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  typedef enum logic [1:0] {IDLE, LATCH, UPDATE, RAISE} state_t;

  localparam logic signed [9:0] MAX_X = 10'(LIMIT_X - 1);
  localparam logic signed [9:0] MAX_Y = 10'(LIMIT_Y - 1);
  localparam logic [7:0] X_RESET = 8'(LIMIT_X / 2);
  localparam logic [7:0] Y_RESET = 8'(LIMIT_Y / 2);

  state_t state_reg, state_next;

  logic [3:0]        status_hold_reg;
  logic [7:0]        dx_hold_reg, dy_hold_reg;
  logic signed [9:0] dx_reg, dy_reg;
  logic [7:0]        x_reg, y_reg, status_reg;
  logic [7:0]        x_next, y_next;
  logic [7:0]        data_out_reg, data_out_next;
  logic              oe_reg, oe_next;
  logic              raise_reg;

  logic capture, latch_en, update_en, raise_set;
  logic signed [9:0] nx_sum, ny_sum;
  logic [7:0] addr_offset;
  logic       read_hit;

  function automatic logic [7:0] clamp(input logic signed [9:0] v, input logic signed [9:0] hi);
    if (v < 10'sd0)
      return 8'd0;
    else if (v > hi)
      return hi[7:0];
    else
      return v[7:0];
  endfunction

  // FSM: state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // FSM: next state; strobes outside IDLE are simply not looked at
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (SEND_INTERRUPT) state_next = LATCH;
      LATCH:   state_next = UPDATE;
      UPDATE:  state_next = RAISE;
      RAISE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    capture   = 1'b0;
    latch_en  = 1'b0;
    update_en = 1'b0;
    raise_set = 1'b0;
    case (state_reg)
      IDLE:    capture   = SEND_INTERRUPT;
      LATCH:   latch_en  = 1'b1;
      UPDATE:  update_en = 1'b1;
      RAISE:   raise_set = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      status_hold_reg <= 4'd0;
      dx_hold_reg     <= 8'd0;
      dy_hold_reg     <= 8'd0;
      dx_reg          <= 10'sd0;
      dy_reg          <= 10'sd0;
    end else begin
      if (capture) begin
        status_hold_reg <= MOUSE_STATUS;
        dx_hold_reg     <= MOUSE_DX;
        dy_hold_reg     <= MOUSE_DY;
      end
      // 9-bit two's complement sign-extended to 10 bits so +/-255 never wraps
      if (latch_en) begin
        dx_reg <= {status_hold_reg[1], status_hold_reg[1], dx_hold_reg};
        dy_reg <= {status_hold_reg[0], status_hold_reg[0], dy_hold_reg};
      end
    end
  end

  // Screen Y grows downward, so a positive mouse DY moves the cursor up
  assign nx_sum = $signed({2'b00, x_reg}) + dx_reg;
  assign ny_sum = $signed({2'b00, y_reg}) - dy_reg;

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (update_en) begin
      x_next = clamp(nx_sum, MAX_X);
      y_next = clamp(ny_sum, MAX_Y);
    end
`ifdef MOUSE_BUS_WRITE_POS_EN
    // Bus write applied last so it overrides a coinciding update
    if (BUS_WE && BUS_ADDR == BASE_ADDR + 8'd1)
      x_next = clamp($signed({2'b00, BUS_DATA_IN}), MAX_X);
    if (BUS_WE && BUS_ADDR == BASE_ADDR + 8'd2)
      y_next = clamp($signed({2'b00, BUS_DATA_IN}), MAX_Y);
`endif
  end

`ifndef MOUSE_BUS_WRITE_POS_EN
  logic unused_bus_data;
  assign unused_bus_data = ^BUS_DATA_IN;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      x_reg      <= X_RESET;
      y_reg      <= Y_RESET;
      status_reg <= 8'd0;
    end else begin
      x_reg <= x_next;
      y_reg <= y_next;
      if (update_en)
        status_reg <= {4'b0000, status_hold_reg};
    end
  end

  // Offset compare handles bases near the top of the address space
  assign addr_offset = BUS_ADDR - BASE_ADDR;
  assign read_hit    = !BUS_WE && (addr_offset < 8'd3);

  always_comb begin
    oe_next       = read_hit;
    data_out_next = 8'd0;
    if (read_hit) begin
      case (addr_offset)
        8'd0:    data_out_next = status_reg;
        8'd1:    data_out_next = x_reg;
        default: data_out_next = y_reg;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_out_reg <= 8'd0;
      oe_reg       <= 1'b0;
    end else begin
      data_out_reg <= data_out_next;
      oe_reg       <= oe_next;
    end
  end

  // A new raise takes priority over a coinciding acknowledge
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      raise_reg <= 1'b0;
    else if (raise_set)
      raise_reg <= 1'b1;
    else if (BUS_INTERRUPT_ACK)
      raise_reg <= 1'b0;
  end

  assign BUS_DATA_OUT        = data_out_reg;
  assign BUS_DATA_OE         = oe_reg;
  assign BUS_INTERRUPT_RAISE = raise_reg;

endmodule

// File: tb/tb_mouse_bus_interface.sv
// Directed-vector bench for mouse_bus_interface; expected positions are hand-computed.
// Write-path expectations follow MOUSE_BUS_WRITE_POS_EN when it is defined.
module tb_mouse_bus_interface;

  logic       CLK;
  logic       RESET;
  logic [3:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX, MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic [7:0] BUS_DATA_IN;
  logic [7:0] BUS_DATA_OUT;
  logic       BUS_DATA_OE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  mouse_bus_interface #(.BASE_ADDR(8'hA0), .LIMIT_X(160), .LIMIT_Y(120)) dut (
    .CLK(CLK), .RESET(RESET),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
    .SEND_INTERRUPT(SEND_INTERRUPT),
    .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE), .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_DATA_OUT(BUS_DATA_OUT), .BUS_DATA_OE(BUS_DATA_OE),
    .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE), .BUS_INTERRUPT_ACK(BUS_INTERRUPT_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else
      $display("ok   %s: %0d", tag, got);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input int exp_oe, input int exp_data);
    BUS_ADDR = a;
    BUS_WE   = 1'b0;
    tick();
    check({tag, "_oe"}, int'(BUS_DATA_OE), exp_oe);
    check({tag, "_data"}, int'(BUS_DATA_OUT), exp_data);
    BUS_ADDR = 8'h00;
  endtask

  // Leaves the bench in cycle N+4, FSM back in IDLE
  task automatic pkt(input logic [3:0] st, input logic [7:0] dx, input logic [7:0] dy);
    MOUSE_STATUS   = st;
    MOUSE_DX       = dx;
    MOUSE_DY       = dy;
    SEND_INTERRUPT = 1'b1;
    tick();
    SEND_INTERRUPT = 1'b0;
    repeat (3) tick();
  endtask

  task automatic ack_pulse();
    BUS_INTERRUPT_ACK = 1'b1;
    tick();
    BUS_INTERRUPT_ACK = 1'b0;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR    = a;
    BUS_WE      = 1'b1;
    BUS_DATA_IN = d;
    tick();
    BUS_WE   = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  initial begin
    RESET = 1'b0;
    MOUSE_STATUS = 4'd0; MOUSE_DX = 8'd0; MOUSE_DY = 8'd0;
    SEND_INTERRUPT = 1'b0;
    BUS_ADDR = 8'h00; BUS_WE = 1'b0; BUS_DATA_IN = 8'd0;
    BUS_INTERRUPT_ACK = 1'b0;
    repeat (2) tick();

    check("rst_oe", int'(BUS_DATA_OE), 0);
    check("rst_data", int'(BUS_DATA_OUT), 0);
    check("rst_raise", int'(BUS_INTERRUPT_RAISE), 0);
    #2 RESET = 1'b1;
    tick();
    rd_chk("rst_x", 8'hA1, 1, 80);
    rd_chk("rst_y", 8'hA2, 1, 60);
    rd_chk("rst_status", 8'hA0, 1, 0);
    check("rst_raise_after", int'(BUS_INTERRUPT_RAISE), 0);

    // Basic packet: +5 right, +3 up, left button; check raise timing
    MOUSE_STATUS = 4'b1000; MOUSE_DX = 8'h05; MOUSE_DY = 8'h03;
    SEND_INTERRUPT = 1'b1;
    tick();
    SEND_INTERRUPT = 1'b0;
    repeat (2) tick();
    check("p1_raise_n3", int'(BUS_INTERRUPT_RAISE), 0);
    tick();
    check("p1_raise_n4", int'(BUS_INTERRUPT_RAISE), 1);
    rd_chk("p1_status", 8'hA0, 1, 8);
    rd_chk("p1_x", 8'hA1, 1, 85);
    rd_chk("p1_y", 8'hA2, 1, 57);
    check("p1_raise_hold", int'(BUS_INTERRUPT_RAISE), 1);
    ack_pulse();
    check("p1_raise_ack", int'(BUS_INTERRUPT_RAISE), 0);

    // Clamp tests
    pkt(4'b0010, 8'h9C, 8'h00);
    rd_chk("clamp_lo_x", 8'hA1, 1, 0);
    rd_chk("clamp_lo_status", 8'hA0, 1, 2);
    pkt(4'b0000, 8'h7F, 8'h00);
    rd_chk("step1_x", 8'hA1, 1, 127);
    pkt(4'b0000, 8'h7F, 8'h00);
    rd_chk("clamp_hi_x", 8'hA1, 1, 159);
    pkt(4'b0000, 8'h7F, 8'h00);
    rd_chk("clamp_hi_x2", 8'hA1, 1, 159);
    rd_chk("clamp_y_kept", 8'hA2, 1, 57);
    pkt(4'b0000, 8'h00, 8'hFF);
    rd_chk("clamp_lo_y", 8'hA2, 1, 0);
    pkt(4'b0001, 8'h00, 8'h01);
    rd_chk("clamp_hi_y", 8'hA2, 1, 119);
    ack_pulse();

    // Second strobe one cycle later is dropped; read issued in UPDATE sees old X
    MOUSE_STATUS = 4'b0010; MOUSE_DX = 8'hF6; MOUSE_DY = 8'h00;
    SEND_INTERRUPT = 1'b1;
    tick();
    MOUSE_STATUS = 4'b0000; MOUSE_DX = 8'h05; MOUSE_DY = 8'h10;
    tick();
    SEND_INTERRUPT = 1'b0;
    rd_chk("upd_read_old_x", 8'hA1, 1, 159);
    repeat (2) tick();
    rd_chk("drop_x", 8'hA1, 1, 149);
    rd_chk("drop_y", 8'hA2, 1, 119);
    rd_chk("drop_status", 8'hA0, 1, 2);
    ack_pulse();
    check("drop_raise_ack", int'(BUS_INTERRUPT_RAISE), 0);

    // ACK coinciding with RAISE set: raise wins
    MOUSE_STATUS = 4'b0000; MOUSE_DX = 8'h01; MOUSE_DY = 8'h00;
    SEND_INTERRUPT = 1'b1;
    tick();
    SEND_INTERRUPT = 1'b0;
    repeat (2) tick();
    BUS_INTERRUPT_ACK = 1'b1;
    tick();
    BUS_INTERRUPT_ACK = 1'b0;
    check("ack_coincide_raise", int'(BUS_INTERRUPT_RAISE), 1);
    tick();
    check("ack_coincide_hold", int'(BUS_INTERRUPT_RAISE), 1);
    rd_chk("coincide_x", 8'hA1, 1, 150);
    rd_chk("bad_addr_a3", 8'hA3, 0, 0);
    rd_chk("bad_addr_00", 8'h00, 0, 0);
    rd_chk("bad_addr_9f", 8'h9F, 0, 0);

    // Asynchronous reset in the UPDATE cycle while OE and RAISE are high
    BUS_ADDR = 8'hA1;
    MOUSE_STATUS = 4'b1100; MOUSE_DX = 8'h05; MOUSE_DY = 8'h05;
    SEND_INTERRUPT = 1'b1;
    tick();
    SEND_INTERRUPT = 1'b0;
    tick();
    check("pre_rst_oe", int'(BUS_DATA_OE), 1);
    #2 RESET = 1'b0;
    #1;
    check("async_rst_oe", int'(BUS_DATA_OE), 0);
    check("async_rst_data", int'(BUS_DATA_OUT), 0);
    check("async_rst_raise", int'(BUS_INTERRUPT_RAISE), 0);
    BUS_ADDR = 8'h00;
    repeat (2) tick();
    #2 RESET = 1'b1;
    tick();
    rd_chk("post_rst_x", 8'hA1, 1, 80);
    rd_chk("post_rst_y", 8'hA2, 1, 60);
    rd_chk("post_rst_status", 8'hA0, 1, 0);
    check("post_rst_raise", int'(BUS_INTERRUPT_RAISE), 0);

    // Bus writes
    bus_wr(8'hA1, 8'd200);
    bus_wr(8'hA2, 8'd33);
    bus_wr(8'hA0, 8'hFF);
`ifdef MOUSE_BUS_WRITE_POS_EN
    rd_chk("wr_x_clamp", 8'hA1, 1, 159);
    rd_chk("wr_y", 8'hA2, 1, 33);
`else
    rd_chk("wr_x_ignored", 8'hA1, 1, 80);
    rd_chk("wr_y_ignored", 8'hA2, 1, 60);
`endif
    rd_chk("wr_status_ignored", 8'hA0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
